pte_cache_fill_unit: RTL



---
 rtl/pte_cache_pkg.sv | 17 +
 rtl/pte_cache_first_free.sv | 23 ++
 rtl/pte_cache_fill_unit.sv | 124 ++++++++++++
 3 files changed

// File: rtl/pte_cache_pkg.sv
// Shared types and sizes for the page-walker PTE cache.
package pte_cache_pkg;

  localparam int ENTRIES   = 8;
  localparam int TAG_W     = 27;
  localparam int PPN_W     = 20;
  localparam int PTE_PPN_W = 38;

  typedef logic [2:0] entry_idx_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [PPN_W-1:0] ppn;
  } entry_t;

endpackage

// File: rtl/pte_cache_first_free.sv
// Priority encoder: lowest invalid entry index plus an any-free flag.
module pte_cache_first_free
  import pte_cache_pkg::*;
(
  input  logic [ENTRIES-1:0] valid,
  output entry_idx_t         first_free,
  output logic               any_free
);

  // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    first_free = '0;
    any_free   = 1'b0;
    // Scan downwards so the lowest invalid index is the last one written.
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        first_free = entry_idx_t'(i);
        any_free   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pte_cache_fill_unit.sv
// Write side of the 8-entry fully associative PTE cache: storage, victim
// selection, refill handshake and the hit vector for the search unit.
module pte_cache_fill_unit
  import pte_cache_pkg::*;
#(
  parameter int ENTRIES = pte_cache_pkg::ENTRIES,
  parameter int TAG_W   = pte_cache_pkg::TAG_W,
  parameter int PPN_W   = pte_cache_pkg::PPN_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [TAG_W-1:0]     lookup_tag,
  input  logic                 flush,
  input  logic                 fill_valid,
  output logic                 fill_ready,
  input  logic [TAG_W-1:0]     fill_tag,
  input  logic [PTE_PPN_W-1:0] pte_ppn,
  output logic [ENTRIES-1:0]   hit_bit,
  output entry_idx_t           replace_entry,
  output logic [PPN_W-1:0]     ppn_0,
  output logic [PPN_W-1:0]     ppn_1,
  output logic [PPN_W-1:0]     ppn_2,
  output logic [PPN_W-1:0]     ppn_3,
  output logic [PPN_W-1:0]     ppn_4,
  output logic [PPN_W-1:0]     ppn_5,
  output logic [PPN_W-1:0]     ppn_6,
  output logic [PPN_W-1:0]     ppn_7
);

  entry_t             entries [ENTRIES];
  entry_idx_t         rr_ptr;

  logic [ENTRIES-1:0] valid_vec;
  logic [ENTRIES-1:0] dup_vec;
  logic [ENTRIES-1:0] match_vec;
  entry_idx_t         first_free;
  logic               any_free;
  entry_idx_t         dup_idx;
  logic               dup_found;
  logic               victim_from_rr;
  logic               fill_fire;
  logic               unused_pte_hi;

  assign unused_pte_hi = ^pte_ppn[PTE_PPN_W-1:PPN_W];

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      valid_vec[i] = entries[i].valid;
      dup_vec[i]   = entries[i].valid && (entries[i].tag == fill_tag);
      match_vec[i] = entries[i].valid && (entries[i].tag == lookup_tag);
    end
  end

  pte_cache_first_free u_first_free (
    .valid      (valid_vec),
    .first_free (first_free),
    .any_free   (any_free)
  );

  // Overwriting a matching tag keeps the cache free of duplicates, which is
  // what guarantees hit_bit stays at most one-hot.
  always_comb begin
    dup_idx   = '0;
    dup_found = 1'b0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (dup_vec[i]) begin
        dup_idx   = entry_idx_t'(i);
        dup_found = 1'b1;
      end
    end

    victim_from_rr = 1'b0;
    if (dup_found) begin
      replace_entry = dup_idx;
    end else if (any_free) begin
      replace_entry = first_free;
    end else begin
      replace_entry  = rr_ptr;
      victim_from_rr = 1'b1;
    end
  end

  assign fill_ready = !flush && !rst;
  assign fill_fire  = fill_valid && fill_ready;

  // Bypass lets the search unit hand back pte_ppn before the write lands.
  always_comb begin
    hit_bit = match_vec;
    if (fill_fire && (fill_tag == lookup_tag)) begin
      hit_bit[replace_entry] = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the tag/PPN storage is reset too, because ppn_N must read zero out of reset.
      for (int i = 0; i < ENTRIES; i++) begin
        entries[i] <= '0;
      end
      rr_ptr <= '0;
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entries[i].valid <= 1'b0;
      end
      rr_ptr <= '0;
    end else if (fill_fire) begin
      entries[replace_entry] <= '{valid: 1'b1, tag: fill_tag, ppn: pte_ppn[PPN_W-1:0]};
      if (victim_from_rr) begin
        rr_ptr <= rr_ptr + entry_idx_t'(1);
      end
    end
  end

  assign ppn_0 = entries[0].ppn;
  assign ppn_1 = entries[1].ppn;
  assign ppn_2 = entries[2].ppn;
  assign ppn_3 = entries[3].ppn;
  assign ppn_4 = entries[4].ppn;
  assign ppn_5 = entries[5].ppn;
  assign ppn_6 = entries[6].ppn;
  assign ppn_7 = entries[7].ppn;

endmodule
